operand_fetch_stage: RTL and testbench

- Decode-to-execute stage of the 8-bit core.
- Holds the 8x8 register file, reads two source registers and captures the operands plus decoded controls into a single-entry ID/EX output register.
- Outputs drive the ALU operand-B 2:1 select (register value vs immediate) and the ALU directly.
- Valid/ready handshake on both sides; supports stall and flush.

---
 rtl/of_pkg.sv | 30 +++
 rtl/operand_fetch_stage_if.sv | 47 ++++
 rtl/reg_file_8x8.sv | 46 ++++
 rtl/operand_fetch_stage.sv | 116 +++++++++++
 tb/tb_operand_fetch_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/of_pkg.sv
// Shared widths, ALU opcode encoding and the ID/EX bundle layout for the operand fetch stage.
package of_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_CNT = 8;
  localparam int ADDR_W  = 3;
  localparam int OP_W    = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_PASS = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    alu_op_e           alu_op;
    logic [ADDR_W-1:0] rd;
    logic              reg_we;
  } idex_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decoder, writeback and execute-side signals of the operand fetch stage.
interface operand_fetch_stage_if
  import of_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int OW = OP_W
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] imm_in;
  logic          alu_src_in;
  logic [OW-1:0] alu_op_in;
  logic [AW-1:0] rd_addr_in;
  logic          reg_we_in;
  logic          flush;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b_reg;
  logic [DW-1:0] imm_out;
  logic          alu_src_sel;
  logic [OW-1:0] alu_op_out;
  logic [AW-1:0] rd_addr_out;
  logic          reg_we_out;

  modport master (
    output in_valid, rs1_addr, rs2_addr, imm_in, alu_src_in, alu_op_in,
           rd_addr_in, reg_we_in, flush, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, op_a, op_b_reg, imm_out, alu_src_sel,
           alu_op_out, rd_addr_out, reg_we_out
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, imm_in, alu_src_in, alu_op_in,
           rd_addr_in, reg_we_in, flush, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, op_a, op_b_reg, imm_out, alu_src_sel,
           alu_op_out, rd_addr_out, reg_we_out
  );

endinterface

// File: rtl/reg_file_8x8.sv
// Register file: async-reset flops, two combinational read ports, one synchronous write port.
module reg_file_8x8
  import of_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int CNT = REG_CNT,
  parameter int AW  = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs_q [CNT];
  logic [DW-1:0] regs_d [CNT];

  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_reg
      always_comb begin
        regs_d[gi] = regs_q[gi];
        if (we && (waddr == AW'(gi))) begin
          regs_d[gi] = wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: register file read plus single-entry ID/EX register with valid/ready.
// Define OF_BYPASS_EN to forward same-cycle writeback data into captured and held operands.
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int DATA_W  = of_pkg::DATA_W,
  parameter int REG_CNT = of_pkg::REG_CNT,
  parameter int ADDR_W  = of_pkg::ADDR_W,
  parameter int OP_W    = of_pkg::OP_W
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_stage_if.slave bus
);

  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [DATA_W-1:0] fetch_a;
  logic [DATA_W-1:0] fetch_b;
  logic              load;

  idex_t idex_q, idex_d;
  logic  valid_q, valid_d;

  reg_file_8x8 #(
    .DW  (DATA_W),
    .CNT (REG_CNT),
    .AW  (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.wb_we),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (bus.rs1_addr),
    .raddr2 (bus.rs2_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef OF_BYPASS_EN
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;

  assign fetch_a = (bus.wb_we && (bus.wb_addr == bus.rs1_addr)) ? bus.wb_data : rf_rdata1;
  assign fetch_b = (bus.wb_we && (bus.wb_addr == bus.rs2_addr)) ? bus.wb_data : rf_rdata2;
`else
  assign fetch_a = rf_rdata1;
  assign fetch_b = rf_rdata2;
`endif

  always_comb begin
    idex_d  = idex_q;
    valid_d = valid_q;
`ifdef OF_BYPASS_EN
    rs1_d = rs1_q;
    rs2_d = rs2_q;
`endif
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d        = 1'b1;
      idex_d.op_a    = fetch_a;
      idex_d.op_b    = fetch_b;
      idex_d.imm     = bus.imm_in;
      idex_d.alu_src = bus.alu_src_in;
      idex_d.alu_op  = alu_op_e'(bus.alu_op_in);
      idex_d.rd      = bus.rd_addr_in;
      idex_d.reg_we  = bus.reg_we_in;
`ifdef OF_BYPASS_EN
      rs1_d = bus.rs1_addr;
      rs2_d = bus.rs2_addr;
`endif
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
`ifdef OF_BYPASS_EN
    // A stalled entry keeps tracking writes to its sources so it never issues stale data.
    else if (valid_q && bus.wb_we) begin
      if (bus.wb_addr == rs1_q) idex_d.op_a = bus.wb_data;
      if (bus.wb_addr == rs2_q) idex_d.op_b = bus.wb_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      valid_q <= 1'b0;
`ifdef OF_BYPASS_EN
      rs1_q   <= '0;
      rs2_q   <= '0;
`endif
    end else begin
      idex_q  <= idex_d;
      valid_q <= valid_d;
`ifdef OF_BYPASS_EN
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
`endif
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.op_a        = idex_q.op_a;
  assign bus.op_b_reg    = idex_q.op_b;
  assign bus.imm_out     = idex_q.imm;
  assign bus.alu_src_sel = idex_q.alu_src;
  assign bus.alu_op_out  = OP_W'(idex_q.alu_op);
  assign bus.rd_addr_out = idex_q.rd;
  assign bus.reg_we_out  = idex_q.reg_we && valid_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow OF_BYPASS_EN when it is defined.
module tb_operand_fetch_stage;
  import of_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  operand_fetch_stage_if ifc ();

  operand_fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.in_valid   = 1'b0;
    ifc.rs1_addr   = '0;
    ifc.rs2_addr   = '0;
    ifc.imm_in     = '0;
    ifc.alu_src_in = 1'b0;
    ifc.alu_op_in  = '0;
    ifc.rd_addr_in = '0;
    ifc.reg_we_in  = 1'b0;
    ifc.flush      = 1'b0;
    ifc.wb_we      = 1'b0;
    ifc.wb_addr    = '0;
    ifc.wb_data    = '0;
    ifc.out_ready  = 1'b1;
  endtask

  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                       input logic src, input logic [3:0] op, input logic [2:0] rd,
                       input logic we);
    ifc.in_valid   = 1'b1;
    ifc.rs1_addr   = rs1;
    ifc.rs2_addr   = rs2;
    ifc.imm_in     = imm;
    ifc.alu_src_in = src;
    ifc.alu_op_in  = op;
    ifc.rd_addr_in = rd;
    ifc.reg_we_in  = we;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [7:0] data);
    ifc.wb_we   = 1'b1;
    ifc.wb_addr = addr;
    ifc.wb_data = data;
  endtask

  initial begin
    idle();
    #12;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_in_ready", ifc.in_ready, 1);
    check("rst_reg_we_out", ifc.reg_we_out, 0);
    check("rst_op_a", ifc.op_a, 0);
    check("rst_imm_out", ifc.imm_out, 0);
    rst_n = 1'b1;
    tick();

    // Preload registers through writeback
    wb(3, 8'h5A); tick();
    wb(4, 8'h0F); tick();
    wb(1, 8'h11); tick();
    wb(5, 8'h20); tick();
    ifc.wb_we = 1'b0;

    // Basic capture
    issue(3, 4, 8'hEE, 1'b0, 4'(ALU_ADD), 6, 1'b1);
    tick();
    ifc.in_valid = 1'b0;
    check("basic_out_valid", ifc.out_valid, 1);
    check("basic_op_a", ifc.op_a, 8'h5A);
    check("basic_op_b", ifc.op_b_reg, 8'h0F);
    check("basic_alu_src", ifc.alu_src_sel, 0);
    check("basic_alu_op", ifc.alu_op_out, 4'(ALU_ADD));
    check("basic_rd", ifc.rd_addr_out, 6);
    check("basic_reg_we", ifc.reg_we_out, 1);

    // Stall for three cycles with a pending instruction
    ifc.out_ready = 1'b0;
    issue(4, 3, 8'h99, 1'b1, 4'(ALU_XOR), 2, 1'b0);
    #1;
    check("stall_in_ready", ifc.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out_valid", ifc.out_valid, 1);
      check("stall_op_a", ifc.op_a, 8'h5A);
      check("stall_imm", ifc.imm_out, 8'hEE);
      check("stall_in_ready", ifc.in_ready, 0);
    end
    ifc.out_ready = 1'b1;
    #1;
    check("release_in_ready", ifc.in_ready, 1);
    tick();
    ifc.in_valid = 1'b0;
    check("release_op_a", ifc.op_a, 8'h0F);
    check("release_op_b", ifc.op_b_reg, 8'h5A);
    check("release_imm", ifc.imm_out, 8'h99);
    check("release_alu_op", ifc.alu_op_out, 4'(ALU_XOR));
    check("release_reg_we", ifc.reg_we_out, 0);
    tick();
    check("drain_out_valid", ifc.out_valid, 0);
    check("drain_op_a_hold", ifc.op_a, 8'h0F);

    // Back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      issue(3'(i), 3'(i), 8'(i), 1'b1, 4'(ALU_PASS), 3'(i), 1'b1);
      tick();
      check("b2b_out_valid", ifc.out_valid, 1);
      check("b2b_imm", ifc.imm_out, i);
      check("b2b_alu_src", ifc.alu_src_sel, 1);
    end
    ifc.in_valid = 1'b0;
    tick();
    check("b2b_end_valid", ifc.out_valid, 0);

    // Flush a held entry plus an incoming one; writeback still lands
    issue(3, 4, 8'h00, 1'b0, 4'(ALU_SUB), 7, 1'b1);
    tick();
    check("pre_flush_reg_we", ifc.reg_we_out, 1);
    ifc.out_ready = 1'b0;
    issue(4, 4, 8'h33, 1'b0, 4'(ALU_OR), 1, 1'b1);
    ifc.flush = 1'b1;
    wb(2, 8'h77);
    tick();
    check("flush_out_valid", ifc.out_valid, 0);
    check("flush_reg_we", ifc.reg_we_out, 0);
    idle();
    issue(2, 0, 8'h00, 1'b0, 4'(ALU_AND), 0, 1'b0);
    tick();
    check("flush_wb_landed", ifc.op_a, 8'h77);

    // Same-cycle writeback to the source being read
    issue(1, 0, 8'h00, 1'b0, 4'(ALU_ADD), 0, 1'b0);
    wb(1, 8'hAA);
    tick();
    ifc.wb_we = 1'b0;
`ifdef OF_BYPASS_EN
    check("same_cycle_op_a", ifc.op_a, 8'hAA);
`else
    check("same_cycle_op_a", ifc.op_a, 8'h11);
`endif
    tick();
    check("after_wb_op_a", ifc.op_a, 8'hAA);

    // Held entry with a later write to its rs2
    issue(0, 5, 8'h00, 1'b0, 4'(ALU_ADD), 3, 1'b1);
    tick();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    check("held_op_b", ifc.op_b_reg, 8'h20);
    wb(5, 8'h3C);
    tick();
    ifc.wb_we = 1'b0;
    check("held_out_valid", ifc.out_valid, 1);
`ifdef OF_BYPASS_EN
    check("held_refresh_op_b", ifc.op_b_reg, 8'h3C);
`else
    check("held_refresh_op_b", ifc.op_b_reg, 8'h20);
`endif

    // Asynchronous reset while stalled
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", ifc.out_valid, 0);
    check("async_rst_reg_we", ifc.reg_we_out, 0);
    check("async_rst_op_b", ifc.op_b_reg, 0);
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", ifc.in_ready, 1);
    issue(3, 4, 8'h00, 1'b0, 4'(ALU_ADD), 0, 1'b0);
    tick();
    check("post_rst_r3", ifc.op_a, 0);
    check("post_rst_r4", ifc.op_b_reg, 0);
    issue(5, 2, 8'h00, 1'b0, 4'(ALU_ADD), 0, 1'b0);
    tick();
    check("post_rst_r5", ifc.op_a, 0);
    check("post_rst_r2", ifc.op_b_reg, 0);
    check("post_rst_valid", ifc.out_valid, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
